// File: rtl/wb_write_queue.sv
// wb_write_queue: buffers pending register-file writes and retires one per
// cycle onto the file's write port (we3/wa3/wd3). Queued values are also
// forwarded to the two read ports so that readers see the newest pending data.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       drain_hold,
    output logic                       we3,
    output logic [AW-1:0]              wa3,
    output logic [DW-1:0]              wd3,
    input  logic [AW-1:0]              ra1,
    input  logic [AW-1:0]              ra2,
    output logic                       fwd1_hit,
    output logic [DW-1:0]              fwd1_data,
    output logic                       fwd2_hit,
    output logic [DW-1:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_addrMem [DEPTH];
    logic [DW-1:0] r_dataMem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [DW:0]   w_fwd1;
    logic [DW:0]   w_fwd2;

    // Walks the valid entries oldest to youngest so the youngest match wins.
    // Register 0 is hardwired, so a zero read address never hits.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] ra);
        logic [DW:0]   result;
        logic [PW-1:0] idx;
        result = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (ra != '0) && (r_addrMem[idx] == ra)) begin
                result = {1'b1, r_dataMem[idx]};
            end
        end
        return result;
    endfunction

    assign empty      = (r_count == '0);
    assign full       = (r_count == CW'(DEPTH));
    assign count      = r_count;
    assign push_ready = reset_n & ~full;

    // Writes to register 0 complete the handshake but are never stored.
    assign w_accept = push_valid & push_ready;
    assign w_push   = w_accept & (push_addr != '0);

    // The head entry is presented for the whole cycle and popped at the next
    // rising edge; the file itself commits on the falling edge in between.
    assign we3   = ~empty & ~drain_hold & reset_n;
    assign w_pop = we3;

    // Head entry drives the write port; zero whenever nothing is queued.
    always_comb begin
        wa3 = '0;
        wd3 = '0;
        if (!empty && reset_n) begin
            wa3 = r_addrMem[r_head];
            wd3 = r_dataMem[r_head];
        end
    end

    // Forwarding lookups for both read ports, suppressed while in reset.
    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        if (reset_n) begin
            w_fwd1 = lookup(ra1);
            w_fwd2 = lookup(ra2);
        end
    end

    assign fwd1_hit  = w_fwd1[DW];
    assign fwd1_data = w_fwd1[DW-1:0];
    assign fwd2_hit  = w_fwd2[DW];
    assign fwd2_data = w_fwd2[DW-1:0];

    // Entry storage; validity is tracked by the pointers and count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addrMem[r_tail] <= push_addr;
            r_dataMem[r_tail] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards every queued write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writer-side front end for the 3-port register file: buffers pending register writes from the datapath and retires them one per cycle onto the file's write port (we3/wa3/wd3).
- The register file commits on the falling edge of clk. This block therefore presents a stable write from the rising edge and retires the entry at the next rising edge.
- Provides a forwarding lookup so readers of ra1/ra2 see queued, not-yet-committed values (newest wins).

Parameters:
DEPTH, 4, number of queue entries (power of two, >= 2)
DW, 32, data width
AW, 5, register address width

Ports:
clk  input  1  system clock, rising-edge registers
reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
push_valid  input  1  producer has a write request
push_ready  output  1  queue can accept a request this cycle
push_addr  input  AW  destination register
push_data  input  DW  write data
drain_hold  input  1  inhibit retirement this cycle (write port borrowed)
we3  output  1  register file write enable
wa3  output  AW  register file write address
wd3  output  DW  register file write data
ra1  input  AW  read address 1 (same as register file ra1)
ra2  input  AW  read address 2
fwd1_hit  output  1  a queued entry matches ra1
fwd1_data  output  DW  newest queued data for ra1
fwd2_hit  output  1  a queued entry matches ra2
fwd2_data  output  DW  newest queued data for ra2
count  output  clog2(DEPTH)+1  entries held
empty  output  1  count==0
full  output  1  count==DEPTH

Behaviour:
- Storage: circular buffer with head/tail pointers and a count register, each entry holding {addr, data}.
- Reset, synchronous on reset_n==0 at a rising edge:
  - head=tail=0, count=0, all queued entries discarded.
  - Outputs during and after reset until the next push: we3=0, wa3=0, wd3=0, fwd*_hit=0, fwd*_data=0, empty=1, full=0, push_ready=0 while reset_n==0.
- push_ready = reset_n & ~full. It depends only on registered count, not on a same-cycle pop.
- Accept condition is push_valid & push_ready, taken at the rising edge.
  - push_addr==0: request is accepted (handshake completes) but not enqueued, because register 0 is hardwired to 0.
  - Otherwise the request is written at tail; tail and count increment.
- Retire: we3 = ~empty & ~drain_hold & reset_n. wa3/wd3 are driven from the head entry whenever ~empty, and are 0 when empty.
  - A rising edge with we3=1 pops the head: head increments, count decrements.
- Latency: a request accepted at edge N appears on we3 no earlier than cycle N+1. There is no combinational push-to-we3 path.
- Simultaneous push (addr!=0) and pop: count unchanged, both pointers advance.
- Pointer wrap-around is modulo DEPTH. full/empty come from count, never from pointer equality.
- Ordering is strict FIFO. Multiple entries to the same address retire in push order, so the last value wins in the file.
- Forwarding (combinational), evaluated over all valid entries including the head:
  - fwdX_hit=1 iff raX!=0 and some valid entry has addr==raX.
  - fwdX_data is the data of the youngest such entry (closest to tail), else 0.
  - raX==0 always gives hit=0, data=0.
- drain_hold while empty has no effect. drain_hold while full keeps push_ready=0.
- Reset asserted mid-operation drops every queued write. No partial retirement occurs in that cycle: we3=0.

Test Plan:
- Reset then a single push {addr=5, data=32'hDEADBEEF} at edge 1 -> cycle 1: we3=0; cycle 2: we3=1, wa3=5, wd3=DEADBEEF; cycle 3: empty=1, we3=0.
- drain_hold=1, push addr 1..4 with data 10..40 -> full=1, push_ready=0, count=4; a 5th push_valid is held off. Release drain_hold -> we3 retires r1..r4 in order over 4 cycles.
- Push r7=1, r7=2, r7=3 with drain_hold=1, ra1=7 -> fwd1_hit=1, fwd1_data=3. Pop once -> data still 3. Drain all -> fwd1_hit=0.
- Push addr=0 data=FFFF_FFFF -> handshake completes, count stays 0, we3 never asserts; ra2=0 -> fwd2_hit=0.
- Steady state with count=2, push and pop every cycle for 10 cycles -> count stays 2, pointers wrap past DEPTH, retire order matches push order.
- Queue holding 3 entries, reset_n=0 for one edge -> count=0, we3=0, fwd hits 0; a following push behaves as in the first scenario.
